// File: rtl/cdc_xfer_arbiter_if.sv
// cdc_xfer_arbiter_if: requester bus and req/ack crossing signals of the CDC transfer arbiter
interface cdc_xfer_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [DATA_WIDTH-1:0]         xfer_data_o;
  logic                          xfer_req_o;
  logic                          xfer_ack_i;
  logic [$clog2(NUM_REQ)-1:0]    grant_id_o;
  logic                          busy_o;
  logic                          done_o;
  logic                          timeout_o;
  modport master (
    input  req_valid_i, req_data_i, xfer_ack_i,
    output req_ready_o, xfer_data_o, xfer_req_o, grant_id_o, busy_o, done_o, timeout_o
  );
  modport slave (
    output req_valid_i, req_data_i, xfer_ack_i,
    input  req_ready_o, xfer_data_o, xfer_req_o, grant_id_o, busy_o, done_o, timeout_o
  );
endinterface

// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: round-robin arbiter sharing one 4-phase req/ack crossing; CDC_XFER_TIMEOUT_EN adds an ack-wait abort
module cdc_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_in_a,
  input  logic               srst_master_n,
  cdc_xfer_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("cdc_xfer_arbiter: parameter out of range");
  end
  state_t                r_state, w_state_nx;
  logic                  r_req, w_req_nx;
  logic                  r_done, w_done_nx;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IW-1:0]         r_grant, r_rr_ptr, w_win;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_found, w_accept, w_tmo, w_aborted;
  int                    w_sum;
  // round-robin scan upward from the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = int'(r_rr_ptr) + k;
      w_sum = (w_sum >= NUM_REQ) ? w_sum - NUM_REQ : w_sum;
      if (!w_found && bus.req_valid_i[w_sum]) begin
        w_found = 1'b1;
        w_win   = IW'(w_sum);
      end
    end
  end
  // accept only in IDLE, out of reset, and once any stale ack has fallen
  assign w_accept = srst_master_n && r_state == IDLE && w_found && !bus.xfer_ack_i;
  // one-hot accept strobe for the winner
  always_comb begin
    w_ready = '0;
    if (w_accept) w_ready[w_win] = 1'b1;
  end
  // next state of the handshake sequencer
  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_req;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_nx = REQ;
        w_req_nx   = 1'b1;
      end
      REQ: if (bus.xfer_ack_i || w_tmo) begin
        w_state_nx = ACK;
        w_req_nx   = 1'b0;
      end
      ACK: if (!bus.xfer_ack_i) begin
        w_state_nx = IDLE;
        w_done_nx  = !w_aborted;
      end
      default: begin
        w_state_nx = IDLE;
        w_req_nx   = 1'b0;
      end
    endcase
  end
  // state, request and hold register; data only moves on an accept edge
  always_ff @(posedge clk_in_a) begin
    if (!srst_master_n) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_req    <= w_req_nx;
      r_done   <= w_done_nx;
      r_data   <= w_accept ? bus.req_data_i[w_win*DATA_WIDTH +: DATA_WIDTH] : r_data;
      r_grant  <= w_accept ? w_win : r_grant;
      r_rr_ptr <= w_accept ? ((w_win == IW'(NUM_REQ-1)) ? '0 : w_win + 1'b1) : r_rr_ptr;
    end
  end
`ifdef CDC_XFER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] r_cnt;
  logic          r_aborted, r_timeout;
  assign w_tmo     = r_state == REQ && r_cnt == CW'(TIMEOUT_CYCLES-1);
  assign w_aborted = r_aborted;
  // ack-wait counter; abort marks the transfer so its ACK exit gives no done
  always_ff @(posedge clk_in_a) begin
    if (!srst_master_n) begin
      r_cnt     <= '0;
      r_aborted <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_accept ? '0 : (r_state == REQ) ? r_cnt + 1'b1 : r_cnt;
      r_aborted <= (w_tmo && !bus.xfer_ack_i) ? 1'b1 : (r_state == ACK && !bus.xfer_ack_i) ? 1'b0 : r_aborted;
      r_timeout <= w_tmo && !bus.xfer_ack_i;
    end
  end
  assign bus.timeout_o = r_timeout;
`else
  assign w_tmo         = 1'b0;
  assign w_aborted     = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif
  assign bus.req_ready_o = w_ready;
  assign bus.xfer_data_o = r_data;
  assign bus.xfer_req_o  = r_req;
  assign bus.grant_id_o  = r_grant;
  assign bus.busy_o      = r_state != IDLE;
  assign bus.done_o      = r_done;
endmodule
